// File: rtl/fflop.sv
// N-bit register with write enable and asynchronous active-low clear to INIT.
// out is driven straight from the register, so there is no combinational path from in.
module fflop #(
   parameter int unsigned N    = 8,
   parameter logic [N-1:0] INIT = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [N-1:0] in,
   output logic [N-1:0] out
);

   logic [N-1:0] r_q;

   // Clear wins over a write landing in the same time step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q <= INIT;
      end else if (we) begin
         r_q <= in;
      end
   end

   assign out = r_q;

endmodule

// File: tb/tb_fflop.sv
// Directed bench for fflop: an 8-bit and a 1-bit instance share clk, reset and we.
// A stored-value model is checked on every falling edge, alongside literal spot checks.
module tb_fflop;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       we    = 1'b0;
   logic [7:0] in8   = 8'h00;
   logic [0:0] in1   = 1'b0;
   logic [7:0] out8;
   logic [0:0] out1;

   int tests = 0;
   int fails = 0;

   // Model state: the value each register is supposed to hold.
   logic [7:0] m8;
   logic [0:0] m1;
   bit         model_valid = 1'b0;

   fflop #(.N(8), .INIT(8'h00)) u_dut8 (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .in    (in8),
      .out   (out8)
   );

   fflop #(.N(1), .INIT(1'b0)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .in    (in1),
      .out   (out1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at t=%0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   // Reset forgets everything; a write-enabled edge outside reset stores the input.
   always @(negedge reset) begin
      m8 = 8'h00;
      m1 = 1'b0;
      model_valid = 1'b1;
   end

   always @(posedge clk) begin
      if (reset === 1'b1 && we === 1'b1) begin
         m8 = in8;
         m1 = in1;
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         chk("model8", out8, m8);
         chk("model1", {7'b0, out1}, {7'b0, m1});
      end
   end

   logic [7:0] vec8 [8];
   logic [7:0] pat1;

   initial begin
      vec8[0] = 8'h01; vec8[1] = 8'h80; vec8[2] = 8'hFF; vec8[3] = 8'h00;
      vec8[4] = 8'h5A; vec8[5] = 8'hA5; vec8[6] = 8'h7E; vec8[7] = 8'hC3;
      pat1 = 8'b0110_1001;

      #1 reset = 1'b0;                                   // t=1
      #1 chk("reset_state8", out8, 8'h00);               // t=2
      chk("reset_state1", {7'b0, out1}, 8'h00);
      reset = 1'b1; we = 1'b1; in8 = 8'hAA; in1 = 1'b1;
      #6 chk("load", out8, 8'hAA);                       // t=8
      chk("load1", {7'b0, out1}, 8'h01);
      in8 = 8'hBB; we = 1'b0;
      #8 chk("hold", out8, 8'hAA);                       // t=16
      reset = 1'b0; we = 1'b1; in8 = 8'hBB;
      #1 chk("async_clear", out8, 8'h00);                // t=17
      #9 chk("clear_held", out8, 8'h00);                 // t=26
      #2 reset = 1'b1; we = 1'b1; in8 = 8'hBB;           // t=28
      #1 chk("release_wait", out8, 8'h00);               // t=29
      #7 chk("release_load", out8, 8'hBB);               // t=36
      // Between-edge activity on in/we must not reach out.
      #2 in8 = 8'h11; we = 1'b0;                         // t=38
      #2 in8 = 8'h22; we = 1'b1;                         // t=40
      #2 chk("no_midcycle_effect", out8, 8'hBB);         // t=42
      #4 chk("load_after_glitch", out8, 8'h22);          // t=46
      #2 we = 1'b0; in8 = 8'h33;                         // t=48
      #2 we = 1'b1;                                      // t=50
      #3 we = 1'b0;                                      // t=53
      #3 chk("we_sampled_at_edge", out8, 8'h22);         // t=56

      we = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in1 = pat1[i];
         in8 = vec8[i];
         @(posedge clk);
         #1;
         chk("n1_follow", {7'b0, out1}, {7'b0, pat1[i]});
         chk("n8_follow", out8, vec8[i]);
      end

      // Reset falling in the same step as a write-enabled edge.
      @(negedge clk);
      in8 = 8'hFF; in1 = 1'b1; we = 1'b1;
      @(posedge clk);
      reset = 1'b0;
      #1 chk("reset_priority8", out8, 8'h00);
      chk("reset_priority1", {7'b0, out1}, 8'h00);
      @(negedge clk);
      reset = 1'b1; we = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("hold_init_after_release", out8, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fflop.md
FFLOP -- requirements
Module: fflop

Interface
REQ-001 Parameter N, default 8: data width in bits; the block SHALL support any N >= 1.
REQ-002 Parameter INIT, default 0 (N bits): value loaded into the register by reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset; reset=0 clears, reset=1 runs.
REQ-005 Port we, input, 1 bit: write enable; 1 captures in on the next rising clk edge, 0 holds.
REQ-006 Port in, input, N bits: data to be stored.
REQ-007 Port out, output, N bits: current stored value, driven directly from the register with no combinational path from in.

Function
REQ-008 The block SHALL contain exactly one N-bit register whose value is presented continuously on out.
REQ-009 On a rising clk edge with reset=1 and we=1, the register SHALL load in, and out SHALL show the new value after the edge (1-cycle latency).
REQ-010 On a rising clk edge with reset=1 and we=0, the register SHALL keep its value.
REQ-011 Changes on in or we between clock edges SHALL NOT affect out.
REQ-012 All N bits SHALL be captured together; there is no partial write, truncation or sign handling.
REQ-013 Setup and hold are judged only at the rising clk edge; the value of we sampled at that edge alone decides load or hold.
REQ-014 The block SHALL have no other state, no handshake and no status outputs.

Reset
REQ-015 When reset goes to 0, out SHALL become INIT at once, without waiting for a clk edge.
REQ-016 While reset=0, out SHALL stay at INIT regardless of clk, we and in; reset has priority over we.
REQ-017 When reset returns to 1, the register SHALL hold INIT until the first rising clk edge with we=1.
REQ-018 Reset asserted mid-operation, including in the same time step as a clk edge with we=1, SHALL result in out=INIT.
REQ-019 The block SHALL define no power-up value other than via reset; benches SHALL apply reset before checking out.

Verification (N=8, INIT=0, clk period 10, rising edges at 5, 15, 25, ...)
REQ-020 Load:
- Stimulus: reset=1, we=1, in=8'hAA before the edge at t=5.
- Response: out=8'hAA after t=5.

REQ-021 Hold:
- Stimulus: after the load above, in=8'hBB and we=0 at t=8.
- Response: out stays 8'hAA across the edge at t=15.

REQ-022 Asynchronous clear:
- Stimulus: with out=8'hAA, drive reset=0 at t=16, between edges, with we=1 and in=8'hBB.
- Response: out=8'h00 immediately, and out stays 8'h00 across the edge at t=25 while reset=0.

REQ-023 Release:
- Stimulus: reset=1 at t=28, we=1, in=8'hBB.
- Response: out remains 8'h00 until the edge at t=35, then out=8'hBB.

REQ-024 Width and priority:
- Stimulus (N=1 instance): toggle in under we=1.
- Response (N=1 instance): out follows in one edge late.
- Stimulus (N=8 instance): reset=0 coincident with a clk edge, we=1, in=8'hFF.
- Response (N=8 instance): out=8'h00.
